or4_rr_arbiter: RTL
===================

Name: or4_rr_arbiter

Overview:
- Round-robin arbiter that shares one 4-input OR resource among four requesters a, b, c, d.
- Issues a registered one-hot grant and holds it while the owner keeps requesting.
- Exposes the combinational OR of all requests as the shared "any request" line (e), matching the existing four-input OR function.
- Sits between requester logic and the shared OR resource; it is the sequencing layer above the gate.

Parameters:
- MAX_HOLD, 8: maximum consecutive grant cycles per owner when the optional feature is on; legal range 2..15.
- HOLD_W, 4: width of the hold counter; must satisfy 2^HOLD_W > MAX_HOLD.

Ports:
- clk  input  1  single system clock, rising edge.
- rst  input  1  synchronous, active-high reset.
- a  input  1  request from requester 0.
- b  input  1  request from requester 1.
- c  input  1  request from requester 2.
- d  input  1  request from requester 3.
- e  output  1  any request: combinational a|b|c|d, unregistered.
- gnt  output  4  one-hot grant, bit i = requester i, registered.
- gnt_valid  output  1  registered; equals |gnt.
- gnt_id  output  2  registered index of the current owner; 0 when idle.

Behaviour:
- Clock and reset: one clock, clk. Reset rst is synchronous and active-high, sampled on the rising edge of clk only.
- Reset values: gnt=4'b0000, gnt_valid=0, gnt_id=2'd0, state=IDLE, last pointer=3 (requester 0 has top priority first), hold counter=0. e stays combinational and is unaffected by rst.
- Priority: search starts at (last+1) mod 4 and wraps through 3 to 0. Whenever a new grant is issued, last is set to the winner.
- IDLE state:
  - If any request is sampled high at edge n, gnt shows the winner after edge n. Latency is 1 cycle; state moves to BUSY.
  - If no request is high, stay in IDLE with all outputs 0.
- BUSY state:
  - Owner request still high: grant held unchanged.
  - Owner request low at edge n, with other requests pending: the new winner is granted at the same edge n. No dead cycle.
  - Owner request low at edge n, with no requests pending: gnt=0 and state returns to IDLE at edge n.
  - Owner drops and re-raises its request immediately: it only wins again if nobody else is requesting, because it now has lowest priority.
- Simultaneous events: all four requesters asserting in the same cycle are resolved by the pointer alone. Exactly one grant bit is ever high.
- Non-owner request pulses: a pulse shorter than one cycle between edges is not seen. Only edge-sampled values count.
- Reset mid-grant: rst has priority over every transition. Grant clears at that edge and the pointer returns to 3, whatever the request state.
- Hold counter:
  - Cleared on every new grant and in IDLE.
  - Increments each BUSY cycle and saturates at MAX_HOLD-1; it never wraps.
  - It is only used when the optional feature is compiled in.
- Invariants: gnt_valid == |gnt; gnt_id == index of the set gnt bit; gnt is always one-hot or zero.

Optional Feature:
- Macro: OR4_ARB_HOLD_LIMIT_EN.
- Defined:
  - If the hold counter equals MAX_HOLD-1 and at least one other requester is high at edge n, the grant is forcibly rotated at edge n to the next requester by priority.
  - The evicted owner keeps lowest priority.
  - If no other requester is pending, the owner keeps the grant and the counter stays saturated.
- Undefined: no tenure limit. The grant is held until the owner's request drops. Counter logic may be removed by synthesis.

Test Plan:
- Reset: hold rst=1 for 2 cycles with all requests at 1 -> gnt=0000, gnt_valid=0, gnt_id=0 throughout; e=1 throughout. After release, gnt=0001 one cycle later.
- Single request: c=1 from cycle 5 -> gnt=0100, gnt_id=2 from cycle 6. Drop c at cycle 10 -> gnt=0000, gnt_valid=0 after that edge.
- Round-robin: a=b=c=d=1, each owner drops its request 3 cycles after being granted, then re-raises it -> grant order 0,1,2,3,0 with no idle cycle between grants.
- Reset mid-grant: b owns the grant, assert rst for 1 cycle while a=b=1 -> gnt=0000 after that edge. Next grant goes to a (gnt=0001) because the pointer is back at 3.
- Hold limit, with OR4_ARB_HOLD_LIMIT_EN defined and MAX_HOLD=4: a=b=1 held continuously -> gnt=0001 for 4 cycles, then 0010 for 4 cycles, alternating. With only a=1 -> gnt=0001 is held indefinitely.
- Hold limit, without the macro: same a=b=1 stimulus -> gnt=0001 held for the whole run.

Source files
------------

// File: rtl/or4_rr_arbiter.sv
// ----------------------------------------------------------------------------
// or4_rr_arbiter
//
// Round-robin arbiter that shares one 4-input OR resource among four
// requesters (a, b, c, d). It issues a registered one-hot grant and keeps it
// while the owner keeps requesting. The unregistered OR of all requests is
// exposed on e, the "any request" line.
//
// Optional build macro:
//   OR4_ARB_HOLD_LIMIT_EN - when defined, an owner that has held the grant
//                           for MAX_HOLD cycles is evicted if anyone else is
//                           waiting. When undefined, tenure is unlimited.
//
// Parameters:
//   MAX_HOLD  maximum consecutive grant cycles per owner (2..15)
//   HOLD_W    width of the tenure counter, 2**HOLD_W > MAX_HOLD
//
// Ports:
//   clk        system clock, rising edge
//   rst        synchronous active-high reset
//   a,b,c,d    requests from requesters 0..3
//   e          combinational a|b|c|d (not affected by rst)
//   gnt        registered one-hot grant, bit i = requester i
//   gnt_valid  registered, equals |gnt
//   gnt_id     registered index of the current owner, 0 when idle
// ----------------------------------------------------------------------------
module or4_rr_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int HOLD_W   = 4
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       a,
    input  logic       b,
    input  logic       c,
    input  logic       d,
    output logic       e,
    output logic [3:0] gnt,
    output logic       gnt_valid,
    output logic [1:0] gnt_id
);

    typedef enum logic {
        IDLE = 1'b0,
        BUSY = 1'b1
    } state_t;

    state_t            state_reg, state_next;
    logic [3:0]        gnt_reg, gnt_next;
    logic              gnt_valid_reg;
    logic [1:0]        gnt_id_reg, gnt_id_next;
    logic [1:0]        last_reg, last_next;
    logic [HOLD_W-1:0] hold_reg, hold_next;

    logic [3:0]        req;
    logic [3:0]        cand;
    logic [1:0]        win_id;
    logic              win_found;
    logic [1:0]        scan_idx;
    logic [3:0]        win_onehot;
    logic              owner_req;
    logic              hold_at_limit;
    logic              force_rotate;

    assign req = {d, c, b, a};
    assign e   = |req;

    // Candidates for a new grant never include the current owner. In IDLE
    // gnt_reg is zero so every request is a candidate.
    assign cand      = req & ~gnt_reg;
    assign owner_req = |(req & gnt_reg);

    // Rotating priority search: start just after the last winner and wrap,
    // so the last winner is examined last (lowest priority).
    always_comb begin
        win_id    = last_reg;
        win_found = 1'b0;
        scan_idx  = 2'd0;
        for (int k = 1; k <= 4; k++) begin
            scan_idx = last_reg + 2'(k);
            if (!win_found && cand[scan_idx]) begin
                win_id    = scan_idx;
                win_found = 1'b1;
            end
        end
    end

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_onehot
            assign win_onehot[gi] = (win_id == 2'(gi));
        end
    endgenerate

    assign hold_at_limit = (hold_reg == HOLD_W'(MAX_HOLD - 1));

`ifdef OR4_ARB_HOLD_LIMIT_EN
    // Evict only when someone else is waiting; a lone owner keeps the grant.
    assign force_rotate = hold_at_limit && win_found;
`else
    assign force_rotate = 1'b0;
`endif

    always_comb begin
        state_next  = state_reg;
        gnt_next    = gnt_reg;
        gnt_id_next = gnt_id_reg;
        last_next   = last_reg;
        hold_next   = hold_reg;

        case (state_reg)
            IDLE: begin
                hold_next = '0;
                if (win_found) begin
                    state_next  = BUSY;
                    gnt_next    = win_onehot;
                    gnt_id_next = win_id;
                    last_next   = win_id;
                end
            end
            BUSY: begin
                if (owner_req && !force_rotate) begin
                    // Saturating tenure counter; never wraps.
                    if (!hold_at_limit) begin
                        hold_next = hold_reg + HOLD_W'(1);
                    end
                end else if (win_found) begin
                    // Hand-over in the same edge the owner leaves: no dead cycle.
                    gnt_next    = win_onehot;
                    gnt_id_next = win_id;
                    last_next   = win_id;
                    hold_next   = '0;
                end else begin
                    state_next  = IDLE;
                    gnt_next    = 4'b0000;
                    gnt_id_next = 2'd0;
                    hold_next   = '0;
                end
            end
            default: begin
                state_next  = IDLE;
                gnt_next    = 4'b0000;
                gnt_id_next = 2'd0;
                hold_next   = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg     <= IDLE;
            gnt_reg       <= 4'b0000;
            gnt_valid_reg <= 1'b0;
            gnt_id_reg    <= 2'd0;
            last_reg      <= 2'd3;   // requester 0 has top priority first
            hold_reg      <= '0;
        end else begin
            state_reg     <= state_next;
            gnt_reg       <= gnt_next;
            gnt_valid_reg <= |gnt_next;
            gnt_id_reg    <= gnt_id_next;
            last_reg      <= last_next;
            hold_reg      <= hold_next;
        end
    end

    assign gnt       = gnt_reg;
    assign gnt_valid = gnt_valid_reg;
    assign gnt_id    = gnt_id_reg;

endmodule
